// File: rtl/eespfal_lane_sequencer.sv
// Lane sequencer for EESPFAL switch macros: latches single-rail operands, drives dual-rail
// inputs and CLK/Dis phases per lane, then captures s/s_bar with rail-error detection.

module eespfal_lane_slice #(
    parameter int BIT_SIZE = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                act_nxt,
    input  logic                rail_en_nxt,
    input  logic                dis_en_nxt,
    input  logic                clk_en_nxt,
    input  logic                cap_en,
    input  logic                clr,
    input  logic [BIT_SIZE-1:0] x_i,
    input  logic [BIT_SIZE-1:0] k_i,
    input  logic [BIT_SIZE-1:0] s_i,
    input  logic [BIT_SIZE-1:0] s_bar_i,
    output logic [BIT_SIZE-1:0] clk_o,
    output logic [BIT_SIZE-1:0] dis_o,
    output logic [BIT_SIZE-1:0] x_o,
    output logic [BIT_SIZE-1:0] x_bar_o,
    output logic [BIT_SIZE-1:0] k_o,
    output logic [BIT_SIZE-1:0] k_bar_o,
    output logic [BIT_SIZE-1:0] res_s_o,
    output logic [BIT_SIZE-1:0] rail_err_o
);
    logic [BIT_SIZE-1:0] rail_on;
    logic [BIT_SIZE-1:0] clk_d, dis_d, x_d, x_bar_d, k_d, k_bar_d, res_s_d, rail_err_d;
    logic [BIT_SIZE-1:0] clk_q, dis_q, x_q, x_bar_q, k_q, k_bar_q, res_s_q, rail_err_q;

    // Drives are computed from the next state so they are registered yet aligned to the phase.
    always_comb begin
        rail_on    = {BIT_SIZE{act_nxt & rail_en_nxt}};
        clk_d      = {BIT_SIZE{act_nxt & clk_en_nxt}};
        dis_d      = {BIT_SIZE{act_nxt & dis_en_nxt}};
        x_d        = rail_on & x_i;
        x_bar_d    = rail_on & ~x_i;
        k_d        = rail_on & k_i;
        k_bar_d    = rail_on & ~k_i;
        res_s_d    = res_s_q;
        rail_err_d = rail_err_q;
        if (clr) begin
            res_s_d    = '0;
            rail_err_d = '0;
        end else if (cap_en) begin
            res_s_d    = s_i;
            rail_err_d = ~(s_i ^ s_bar_i);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            clk_q      <= '0;
            dis_q      <= '0;
            x_q        <= '0;
            x_bar_q    <= '0;
            k_q        <= '0;
            k_bar_q    <= '0;
            res_s_q    <= '0;
            rail_err_q <= '0;
        end else begin
            clk_q      <= clk_d;
            dis_q      <= dis_d;
            x_q        <= x_d;
            x_bar_q    <= x_bar_d;
            k_q        <= k_d;
            k_bar_q    <= k_bar_d;
            res_s_q    <= res_s_d;
            rail_err_q <= rail_err_d;
        end
    end

    assign clk_o      = clk_q;
    assign dis_o      = dis_q;
    assign x_o        = x_q;
    assign x_bar_o    = x_bar_q;
    assign k_o        = k_q;
    assign k_bar_o    = k_bar_q;
    assign res_s_o    = res_s_q;
    assign rail_err_o = rail_err_q;
endmodule

module eespfal_lane_sequencer #(
    parameter int LANES    = 4,
    parameter int BIT_SIZE = 4,
    parameter int DIS_CYC  = 2,
    parameter int EVAL_CYC = 3,
    parameter int HOLD_CYC = 1,
    localparam int W       = LANES * BIT_SIZE
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [W-1:0]     x_i,
    input  logic [W-1:0]     k_i,
    input  logic [LANES-1:0] lane_mask_i,
    input  logic             seq_mode_i,
    output logic [W-1:0]     clk_o,
    output logic [W-1:0]     dis_o,
    output logic             dis_phase_o,
    output logic [W-1:0]     x_o,
    output logic [W-1:0]     x_bar_o,
    output logic [W-1:0]     k_o,
    output logic [W-1:0]     k_bar_o,
    input  logic [W-1:0]     s_i,
    input  logic [W-1:0]     s_bar_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [W-1:0]     res_s_o,
    output logic [W-1:0]     rail_err_o,
    output logic             busy_o
);
    localparam int MAX_DE = (DIS_CYC > EVAL_CYC) ? DIS_CYC : EVAL_CYC;
    localparam int MAX_C  = (MAX_DE > HOLD_CYC) ? MAX_DE : HOLD_CYC;
    localparam int CW     = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_NEXT, ST_DISCH, ST_EVAL, ST_SAMPLE, ST_RECOV, ST_DONE
    } state_e;

    typedef struct packed {
        logic [LANES-1:0][BIT_SIZE-1:0] x;
        logic [LANES-1:0][BIT_SIZE-1:0] k;
        logic                           serial;
    } op_t;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LANES-1:0] act_q, act_d;
    logic [LANES-1:0] pend_q, pend_d;
    op_t              op_q, op_d;
    logic             res_valid_q, res_valid_d;
    logic             dis_phase_q, dis_phase_d;
    logic [LANES-1:0] lowest, sel;
    logic             accept, launch;
    logic             rail_en_nxt, dis_en_nxt, clk_en_nxt;

    assign lowest = pend_q & (~pend_q + LANES'(1));
    assign sel    = op_q.serial ? lowest : pend_q;

    // ST_NEXT only exists right after accept; later lane hand-offs launch from the phase end.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        pend_d  = pend_q;
        op_d    = op_q;
        accept  = 1'b0;
        launch  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid_i) begin
                    accept      = 1'b1;
                    op_d.x      = x_i;
                    op_d.k      = k_i;
                    op_d.serial = seq_mode_i;
                    pend_d      = lane_mask_i;
                    act_d       = '0;
                    state_d     = ST_NEXT;
                end
            end
            ST_NEXT: launch = 1'b1;
            ST_DISCH: begin
                if (cnt_q == '0) begin
                    state_d = ST_EVAL;
                    cnt_d   = CW'(EVAL_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_EVAL: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (HOLD_CYC == 0) begin
                    launch = 1'b1;
                end else begin
                    state_d = ST_RECOV;
                    cnt_d   = CW'(HOLD_CYC - 1);
                end
            end
            ST_RECOV: begin
                if (cnt_q == '0) launch = 1'b1;
                else             cnt_d  = cnt_q - 1'b1;
            end
            ST_DONE: begin
                if (res_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (launch) begin
            if (pend_q == '0) begin
                state_d = ST_DONE;
                act_d   = '0;
            end else begin
                state_d = ST_DISCH;
                cnt_d   = CW'(DIS_CYC - 1);
                act_d   = sel;
                pend_d  = pend_q & ~sel;
            end
        end
    end

    always_comb begin
        rail_en_nxt = (state_d == ST_DISCH) || (state_d == ST_EVAL) || (state_d == ST_SAMPLE);
        dis_en_nxt  = (state_d == ST_DISCH);
        clk_en_nxt  = (state_d == ST_EVAL) || (state_d == ST_SAMPLE);
        dis_phase_d = dis_en_nxt;
        res_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            act_q       <= '0;
            pend_q      <= '0;
            op_q        <= '0;
            res_valid_q <= 1'b0;
            dis_phase_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            op_q        <= op_d;
            res_valid_q <= res_valid_d;
            dis_phase_q <= dis_phase_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        eespfal_lane_slice #(.BIT_SIZE(BIT_SIZE)) u_slice (
            .wb_clk_i    (wb_clk_i),
            .wb_rst_i    (wb_rst_i),
            .act_nxt     (act_d[i]),
            .rail_en_nxt (rail_en_nxt),
            .dis_en_nxt  (dis_en_nxt),
            .clk_en_nxt  (clk_en_nxt),
            .cap_en      ((state_q == ST_SAMPLE) && act_q[i]),
            .clr         (accept),
            .x_i         (op_q.x[i]),
            .k_i         (op_q.k[i]),
            .s_i         (s_i[i*BIT_SIZE +: BIT_SIZE]),
            .s_bar_i     (s_bar_i[i*BIT_SIZE +: BIT_SIZE]),
            .clk_o       (clk_o[i*BIT_SIZE +: BIT_SIZE]),
            .dis_o       (dis_o[i*BIT_SIZE +: BIT_SIZE]),
            .x_o         (x_o[i*BIT_SIZE +: BIT_SIZE]),
            .x_bar_o     (x_bar_o[i*BIT_SIZE +: BIT_SIZE]),
            .k_o         (k_o[i*BIT_SIZE +: BIT_SIZE]),
            .k_bar_o     (k_bar_o[i*BIT_SIZE +: BIT_SIZE]),
            .res_s_o     (res_s_o[i*BIT_SIZE +: BIT_SIZE]),
            .rail_err_o  (rail_err_o[i*BIT_SIZE +: BIT_SIZE])
        );
    end

    assign op_ready_o  = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign res_valid_o = res_valid_q;
    assign dis_phase_o = dis_phase_q;
endmodule
